// File: rtl/fetch_buf_if.sv
// fetch_buf_if: decode handshake, redirect and instruction SRAM signals of the fetch stage
interface fetch_buf_if #(
  parameter int XLEN = 32
);
  logic            bj_taken_i;
  logic [XLEN-1:0] bj_target_i;
  logic            f_valid_o;
  logic            f_ready_i;
  logic [XLEN-1:0] f_pc_o;
  logic [31:0]     f_inst_o;
  logic            f_excp_o;
  logic            inst_sram_en;
  logic [3:0]      inst_sram_we;
  logic [XLEN-1:0] inst_sram_addr;
  logic [31:0]     inst_sram_wdata;
  logic [31:0]     inst_sram_rdata;
  modport master (
    input  bj_taken_i, bj_target_i, f_ready_i, inst_sram_rdata,
    output f_valid_o, f_pc_o, f_inst_o, f_excp_o,
    output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
  );
  modport slave (
    output bj_taken_i, bj_target_i, f_ready_i, inst_sram_rdata,
    input  f_valid_o, f_pc_o, f_inst_o, f_excp_o,
    input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
  );
endinterface

// File: rtl/fetch_buf.sv
// fetch_buf: instruction fetch stage feeding a {pc, inst} FIFO from a 1-cycle-latency SRAM.
// FETCH_ALIGN_CHK_EN turns misaligned redirect targets into a single exception entry plus a fetch halt.
module fetch_buf #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input logic         clk,
  input logic         reset,
  fetch_buf_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d, tgt;
  logic            inflight_q, inflight_d, issue, push, pop, halt_q, excp_q;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [XLEN-1:0] mem_pc_q [FIFO_DEPTH];
  logic [XLEN-1:0] mem_pc_d [FIFO_DEPTH];
  logic [31:0]     mem_inst_q [FIFO_DEPTH];
  logic [31:0]     mem_inst_d [FIFO_DEPTH];
  logic            mem_excp_q [FIFO_DEPTH];
  logic            mem_excp_d [FIFO_DEPTH];
`ifdef FETCH_ALIGN_CHK_EN
  logic halt_d, excp_d;
  assign tgt = bus.bj_target_i;
  always_comb begin
    excp_d = bus.bj_taken_i && (bus.bj_target_i[1:0] != 2'b00);
    halt_d = bus.bj_taken_i ? excp_d : halt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      halt_q <= 1'b0;
      excp_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
      excp_q <= excp_d;
    end
  end
`else
  assign tgt    = bus.bj_target_i & ~XLEN'(3);
  assign halt_q = 1'b0;
  assign excp_q = 1'b0;
`endif
  // in-flight reads reserve a slot, so a push can never overflow
  always_comb begin
    issue      = !reset && !bus.bj_taken_i && !halt_q && ((count_q + CW'(inflight_q)) < CW'(FIFO_DEPTH));
    pop        = (count_q != '0) && bus.f_ready_i;
    push       = !bus.bj_taken_i && (inflight_q || excp_q);
    mem_pc_d   = mem_pc_q;
    mem_inst_d = mem_inst_q;
    mem_excp_d = mem_excp_q;
    if (push) begin
      mem_pc_d[tail_q]   = excp_q ? pc_q : req_pc_q;
      mem_inst_d[tail_q] = excp_q ? NOP : bus.inst_sram_rdata;
      mem_excp_d[tail_q] = excp_q;
    end
    count_d    = bus.bj_taken_i ? '0 : count_q + CW'(push) - CW'(pop);
    head_d     = bus.bj_taken_i ? '0 : head_q + AW'(pop);
    tail_d     = bus.bj_taken_i ? '0 : tail_q + AW'(push);
    pc_d       = bus.bj_taken_i ? tgt : issue ? pc_q + XLEN'(4) : pc_q;
    req_pc_d   = issue ? pc_q : req_pc_q;
    inflight_d = issue;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      mem_pc_q   <= '{default: '0};
      mem_inst_q <= '{default: '0};
      mem_excp_q <= '{default: 1'b0};
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      mem_pc_q   <= mem_pc_d;
      mem_inst_q <= mem_inst_d;
      mem_excp_q <= mem_excp_d;
    end
  end
  assign bus.f_valid_o       = count_q != '0;
  assign bus.f_pc_o          = mem_pc_q[head_q];
  assign bus.f_inst_o        = mem_inst_q[head_q];
  assign bus.f_excp_o        = mem_excp_q[head_q];
  assign bus.inst_sram_en    = issue;
  assign bus.inst_sram_we    = 4'h0;
  assign bus.inst_sram_addr  = pc_q;
  assign bus.inst_sram_wdata = 32'h0;
endmodule

// File: tb/tb_fetch_buf.sv
// tb_fetch_buf: directed plus random stimulus against a queue-based model of the fetch stage
module tb_fetch_buf;
  localparam int D = 4;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        excp;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  fetch_buf_if #(.XLEN(32)) bus ();
  fetch_buf #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(D)) dut (.clk(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.inst_sram_en) bus.inst_sram_rdata <= bus.inst_sram_addr ^ 32'hA5A5_0000;
  ent_t        q[$];
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_req = 32'h0;
  bit          m_infl = 1'b0;
  bit          m_halt = 1'b0;
  bit          m_pend = 1'b0;
  int          tests = 0;
  int          fails = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic bj, input logic [31:0] t, input logic rdy);
    bit en;
    rst = r;
    bus.bj_taken_i = bj;
    bus.bj_target_i = t;
    bus.f_ready_i = rdy;
    @(negedge clk);
    en = !r && !bj && !m_halt && (q.size() + int'(m_infl) < D);
    chk("sram_en", 32'(bus.inst_sram_en), 32'(en));
    if (en) chk("sram_addr", bus.inst_sram_addr, m_pc);
    chk("f_valid", 32'(bus.f_valid_o), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("f_pc", bus.f_pc_o, q[0].pc);
      chk("f_inst", bus.f_inst_o, q[0].inst);
      chk("f_excp", 32'(bus.f_excp_o), 32'(q[0].excp));
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      m_pc = 32'h0;
      m_infl = 1'b0;
      m_halt = 1'b0;
      m_pend = 1'b0;
    end else if (bj) begin
      q.delete();
      m_infl = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
      m_pend = t[1:0] != 2'b00;
      m_halt = m_pend;
      m_pc = t;
`else
      m_pc = {t[31:2], 2'b00};
`endif
    end else begin
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (m_infl) q.push_back('{m_req, m_req ^ 32'hA5A5_0000, 1'b0});
      if (m_pend) q.push_back('{m_pc, 32'h0000_0013, 1'b1});
      m_pend = 1'b0;
      if (en) begin
        m_req = m_pc;
        m_pc = m_pc + 32'd4;
      end
      m_infl = en;
    end
    #1;
  endtask
  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, rdy);
  endtask
  initial begin
    bus.bj_taken_i = 1'b0;
    bus.bj_target_i = 32'h0;
    bus.f_ready_i = 1'b1;
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    chk("reset_addr", bus.inst_sram_addr, 32'h0);
    chk("reset_excp", 32'(bus.f_excp_o), 32'h0);
    chk("sram_we", 32'(bus.inst_sram_we), 32'h0);
    chk("sram_wdata", bus.inst_sram_wdata, 32'h0);
    run(12, 1'b1);
    run(10, 1'b0);
    run(6, 1'b1);
    run(2, 1'b0);
    cyc(1'b0, 1'b1, 32'h100, 1'b0);
    run(6, 1'b1);
    cyc(1'b0, 1'b1, 32'h300, 1'b1);
    run(6, 1'b1);
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    run(6, 1'b1);
    cyc(1'b0, 1'b1, 32'h102, 1'b1);
    run(5, 1'b1);
    cyc(1'b0, 1'b1, 32'h200, 1'b1);
    run(6, 1'b1);
    cyc(1'b0, 1'b1, 32'h400, 1'b1);
    cyc(1'b0, 1'b1, 32'h500, 1'b1);
    run(5, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    run(5, 1'b1);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(99) < 75) t[1:0] = 2'b00;
      cyc($urandom_range(99) < 2, $urandom_range(99) < 8, t, $urandom_range(99) < 70);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
